// File: rtl/cmos_capture.sv
// DVP byte stream to RGB565 pixel assembly with start-up frame skipping.
// Define CMOS_CAPTURE_MEAS_EN to build the line/frame geometry measurement.
`timescale 1ns/1ps

module cmos_capture #(
  parameter logic [3:0]  SKIP_FRAMES = 4'd10,
  parameter logic [11:0] H_DISP      = 12'd1280,
  parameter logic [11:0] V_DISP      = 12'd720
) (
  input  logic        cmos_pclk,
  input  logic        rst_n,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_db,
  input  logic        err_clr,
  output logic        vi_vs,
  output logic        vi_de,
  output logic [15:0] vi_data,
  output logic        frame_valid,
  output logic        line_err,
  output logic [11:0] meas_h,
  output logic [11:0] meas_v,
  output logic        size_ok
);

  // Registered copies of the sensor pins; everything downstream uses these.
  logic        vs_q, vs_dly_q, href_q, href_dly_q;
  logic [7:0]  db_q;
  logic        ph_q, ph_d;
  logic [7:0]  hi_q, hi_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        frame_valid_q, frame_valid_d;
  logic        vi_vs_q, vi_vs_d;
  logic        vi_de_q, vi_de_d;
  logic [15:0] vi_data_q, vi_data_d;
  logic        line_err_q, line_err_d;

  logic vs_rise, href_fall, pix_strobe;

  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
    vs_rise    = vs_q & ~vs_dly_q;
    href_fall  = ~href_q & href_dly_q;
    pix_strobe = href_q & ph_q;

    ph_d = href_q ? ~ph_q : 1'b0;
    hi_d = (href_q && !ph_q) ? db_q : hi_q;

    cnt_d = cnt_q;
    if (vs_rise && (cnt_q != SKIP_FRAMES)) cnt_d = cnt_q + 4'd1;
    frame_valid_d = (cnt_d == SKIP_FRAMES);

    vi_vs_d   = vs_q;
    vi_de_d   = pix_strobe & frame_valid_q;
    vi_data_d = (pix_strobe && frame_valid_q) ? {hi_q, db_q} : vi_data_q;

    // A set on an odd-length line takes priority over a simultaneous clear.
    line_err_d = line_err_q;
    if (err_clr)            line_err_d = 1'b0;
    if (href_fall && ph_q)  line_err_d = 1'b1;
  end

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q          <= 1'b0;
      vs_dly_q      <= 1'b0;
      href_q        <= 1'b0;
      href_dly_q    <= 1'b0;
      db_q          <= 8'd0;
      ph_q          <= 1'b0;
      hi_q          <= 8'd0;
      cnt_q         <= 4'd0;
      frame_valid_q <= (SKIP_FRAMES == 4'd0);
      vi_vs_q       <= 1'b0;
      vi_de_q       <= 1'b0;
      vi_data_q     <= 16'd0;
      line_err_q    <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
      vs_q          <= cmos_vsync;
      vs_dly_q      <= vs_q;
      href_q        <= cmos_href;
      href_dly_q    <= href_q;
      db_q          <= cmos_db;
      ph_q          <= ph_d;
      hi_q          <= hi_d;
      cnt_q         <= cnt_d;
      frame_valid_q <= frame_valid_d;
      vi_vs_q       <= vi_vs_d;
      vi_de_q       <= vi_de_d;
      vi_data_q     <= vi_data_d;
      line_err_q    <= line_err_d;
    end
  end

  assign vi_vs       = vi_vs_q;
  assign vi_de       = vi_de_q;
  assign vi_data     = vi_data_q;
  assign frame_valid = frame_valid_q;
  assign line_err    = line_err_q;

`ifdef CMOS_CAPTURE_MEAS_EN
  logic [11:0] pix_cnt_q, pix_cnt_d;
  logic [11:0] line_cnt_q, line_cnt_d;
  logic [11:0] meas_h_q, meas_h_d;
  logic [11:0] meas_v_q, meas_v_d;
  logic        size_ok_q, size_ok_d;
  logic [11:0] line_inc;

  always_comb begin
    pix_cnt_d  = pix_cnt_q;
    meas_h_d   = meas_h_q;
    meas_v_d   = meas_v_q;
    size_ok_d  = size_ok_q;

    if (href_fall) begin
      if (pix_cnt_q != 12'd0) meas_h_d = pix_cnt_q;
      pix_cnt_d = 12'd0;
    end else if (pix_strobe && (pix_cnt_q != 12'hFFF)) begin
      pix_cnt_d = pix_cnt_q + 12'd1;
    end

    // Include a line ending in this same cycle so it is not lost at the frame boundary.
    line_inc = line_cnt_q;
    if (href_fall && (line_cnt_q != 12'hFFF)) line_inc = line_cnt_q + 12'd1;

    line_cnt_d = line_inc;
    if (vs_rise) begin
      meas_v_d   = line_inc;
      size_ok_d  = (meas_h_d == H_DISP) && (line_inc == V_DISP);
      line_cnt_d = 12'd0;
    end
  end

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_q  <= 12'd0;
      line_cnt_q <= 12'd0;
      meas_h_q   <= 12'd0;
      meas_v_q   <= 12'd0;
      size_ok_q  <= 1'b0;
    end else begin
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      meas_h_q   <= meas_h_d;
      meas_v_q   <= meas_v_d;
      size_ok_q  <= size_ok_d;
    end
  end

  assign meas_h  = meas_h_q;
  assign meas_v  = meas_v_q;
  assign size_ok = size_ok_q;
`else
  logic unused_geom;
  assign unused_geom = ^{H_DISP, V_DISP, href_fall};
  assign meas_h  = 12'd0;
  assign meas_v  = 12'd0;
  assign size_ok = 1'b1;
`endif

endmodule

// File: tb/tb_cmos_capture.sv
// Randomized scoreboard bench for cmos_capture: frame/line model feeds an
// expected-pixel queue that an independent monitor drains and compares.
`timescale 1ns/1ps

module tb_cmos_capture;

  localparam logic [3:0]  SKIP = 4'd2;
  localparam logic [11:0] HD   = 12'd4;
  localparam logic [11:0] VD   = 12'd3;
`ifdef CMOS_CAPTURE_MEAS_EN
  localparam bit MEAS = 1'b1;
`else
  localparam bit MEAS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmos_vsync = 1'b0;
  logic        cmos_href = 1'b0;
  logic [7:0]  cmos_db = 8'd0;
  logic        err_clr = 1'b0;
  logic        vi_vs, vi_de, frame_valid, line_err, size_ok;
  logic [15:0] vi_data;
  logic [11:0] meas_h, meas_v;

  always #5 clk = ~clk;

  cmos_capture #(.SKIP_FRAMES(SKIP), .H_DISP(HD), .V_DISP(VD)) dut (
    .cmos_pclk(clk), .rst_n(rst_n), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
    .cmos_db(cmos_db), .err_clr(err_clr), .vi_vs(vi_vs), .vi_de(vi_de),
    .vi_data(vi_data), .frame_valid(frame_valid), .line_err(line_err),
    .meas_h(meas_h), .meas_v(meas_v), .size_ok(size_ok)
  );

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   de_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // History of the vsync pin as sampled at each rising edge.
  logic [2:0] vs_hist;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) vs_hist <= 3'b000;
    else        vs_hist <= {vs_hist[1:0], cmos_vsync};
  end

  // Monitor: frame_valid / vi_vs reference and scoreboard drain.
  int   mon_cnt = 0;
  logic prev_de = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      mon_cnt = 0;
      prev_de = 1'b0;
    end else begin
      if (vs_hist[1] && !vs_hist[2] && mon_cnt < int'(SKIP)) mon_cnt++;
      check("frame_valid", frame_valid, mon_cnt == int'(SKIP));
      check("vi_vs_delay", vi_vs, vs_hist[1]);
      if (vi_de) begin
        de_count++;
        check("de_spacing", prev_de, 1'b0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pixel_unexpected: vi_data %h but no pixel expected (cycle %0d)", vi_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("pixel_data", vi_data, e.data);
          check("pixel_latency", cyc, e.cyc);
        end
      end
      prev_de = vi_de;
    end
  end

  // Reference model state, updated as stimulus is issued.
  int          drv_vs = 0;
  int          model_lines = 0;
  int          frame_exp_de = 0;
  logic        exp_err = 1'b0;
  logic [11:0] exp_h = 12'd0;
  logic [11:0] exp_v = 12'd0;
  logic        exp_ok = 1'b0;
  logic [7:0]  fixed_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    drv_vs = 0; model_lines = 0; frame_exp_de = 0; de_count = 0;
    exp_err = 1'b0; exp_h = 12'd0; exp_v = 12'd0; exp_ok = 1'b0;
  endtask

  task automatic drive_byte(input int idx, inout logic [7:0] hi, inout int pix);
    logic [7:0] b;
    exp_t e;
    b = (fixed_q.size() != 0) ? fixed_q.pop_front() : 8'($urandom);
    cmos_href = 1'b1;
    cmos_db   = b;
    if (idx % 2 == 0) begin
      hi = b;
    end else begin
      pix++;
      if (drv_vs >= int'(SKIP)) begin
        e.data = {hi, b};
        e.cyc  = cyc + 2;
        exp_q.push_back(e);
        frame_exp_de++;
      end
    end
    step();
  endtask

  task automatic send_line(input int n, input bit collide);
    logic [7:0] hi = 8'd0;
    int pix = 0;
    for (int i = 0; i < n; i++) drive_byte(i, hi, pix);
    cmos_href = 1'b0;
    cmos_db   = 8'($urandom);
    model_lines++;
    if (n % 2 == 1) exp_err = 1'b1;
    if (pix != 0) exp_h = 12'(pix);
    step();
    if (collide) begin
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      repeat (2) step();
    end else begin
      repeat (3) step();
    end
    check("line_err", line_err, exp_err);
    check("meas_h", meas_h, MEAS ? exp_h : 12'd0);
    if (exp_err && $urandom_range(0, 1) == 1) begin
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      exp_err = 1'b0;
      check("err_clr", line_err, 1'b0);
    end
  endtask

  task automatic send_vsync();
    cmos_vsync = 1'b1;
    if (drv_vs < int'(SKIP)) drv_vs++;
    exp_v  = 12'(model_lines);
    exp_ok = (exp_h == HD) && (model_lines == int'(VD));
    model_lines = 0;
    repeat (3) step();
    cmos_vsync = 1'b0;
    repeat (3) step();
    check("meas_v", meas_v, MEAS ? exp_v : 12'd0);
    check("size_ok", size_ok, MEAS ? exp_ok : 1'b1);
    check("frame_de_count", de_count, frame_exp_de);
    de_count = 0;
    frame_exp_de = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vi_vs"}, vi_vs, 1'b0);
    check({tag, "_vi_de"}, vi_de, 1'b0);
    check({tag, "_vi_data"}, vi_data, 16'd0);
    check({tag, "_frame_valid"}, frame_valid, 1'b0);
    check({tag, "_line_err"}, line_err, 1'b0);
    check({tag, "_meas_h"}, meas_h, 12'd0);
    check({tag, "_meas_v"}, meas_v, 12'd0);
    check({tag, "_size_ok"}, size_ok, MEAS ? 1'b0 : 1'b1);
  endtask

  initial begin
    int lines, n;
    logic [7:0] hi;
    int pix;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) step();

    // Frames 0 and 1 are skipped; frame 2 starts with the pairing pattern.
    for (int f = 0; f < 6; f++) begin
      lines = (f == 3) ? 3 : (f == 4) ? 2 : $urandom_range(2, 4);
      for (int l = 0; l < lines; l++) begin
        if (f == 2 && l == 0) begin
          fixed_q = '{8'h12, 8'h34, 8'hAB, 8'hCD};
          send_line(4, 1'b0);
        end else if (f == 3 || f == 4) begin
          send_line(8, 1'b0);
        end else begin
          case ($urandom_range(0, 6))
            0:       n = 7;
            1:       n = 5;
            2:       n = 1;
            3:       n = 6;
            default: n = 8;
          endcase
          send_line(n, (n % 2 == 1) && ($urandom_range(0, 1) == 1));
        end
      end
      send_vsync();
    end

    // Reset in the middle of a line of a forwarded frame.
    hi = 8'd0;
    pix = 0;
    for (int i = 0; i < 3; i++) drive_byte(i, hi, pix);
    #3;
    rst_n = 1'b0;
    cmos_href = 1'b0;
    model_clear();
    #1;
    check_reset_outputs("midline_reset");
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();

    for (int f = 0; f < 3; f++) begin
      for (int l = 0; l < 3; l++) send_line(8, 1'b0);
      send_vsync();
    end

    repeat (5) step();
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
